// File: rtl/soc_boot_pkg.sv
// Shared types and helpers for the SoC boot sequencer.
// State encodings are visible on state_o and must stay fixed.
package soc_boot_pkg;

    localparam int unsigned LOCK_LOSS_CNT_W = 8;

    typedef enum logic [2:0] {
        StWaitLock  = 3'd0,
        StStable    = 3'd1,
        StRstHold   = 3'd2,
        StFetchWait = 3'd3,
        StRun       = 3'd4,
        StHalt      = 3'd5
    } boot_state_t;

    // Width of the shared down-counter: clog2 of the largest period, at least 1 bit.
    // The counter is loaded with period-1, so clog2(period) bits always suffice.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        int unsigned w;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/cdc_sync_bit.sv
// Multi-flop synchronizer for a single asynchronous bit.
// Resets to 0 so a downstream FSM sees "not locked / not held" out of reset.
module cdc_sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/soc_boot_sequencer.sv
// Power-up / clock-loss sequencer: qualifies PLL lock, releases SoC reset,
// then enables fetch; any post-qualification lock loss restarts the sequence.
module soc_boot_sequencer
    import soc_boot_pkg::*;
#(
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned RST_HOLD_CYCLES    = 16,
    parameter int unsigned FETCH_DELAY_CYCLES = 8,
    parameter int unsigned SYNC_STAGES        = 2
) (
    input  logic                       core_clk,
    input  logic                       reset_n,
    input  logic                       locked_i,
    input  logic                       hold_i,
    output logic                       soc_reset_n_o,
    output logic                       fetch_enable_o,
    output logic [2:0]                 state_o,
    output logic [LOCK_LOSS_CNT_W-1:0] lock_loss_cnt_o
);

    localparam int unsigned CntW =
        cnt_width(LOCK_STABLE_CYCLES, RST_HOLD_CYCLES, FETCH_DELAY_CYCLES);

    typedef logic [CntW-1:0]            cnt_t;
    typedef logic [LOCK_LOSS_CNT_W-1:0] loss_t;

    localparam cnt_t  LoadStable = cnt_t'(LOCK_STABLE_CYCLES - 1);
    localparam cnt_t  LoadRst    = cnt_t'(RST_HOLD_CYCLES - 1);
    localparam cnt_t  LoadFetch  = cnt_t'(FETCH_DELAY_CYCLES - 1);
    localparam loss_t LossMax    = '1;

    logic locked_s;
    logic hold_s;

    boot_state_t state_q, state_d;
    cnt_t        cnt_q, cnt_d;
    loss_t       loss_q, loss_d;
    logic        soc_rst_n_q, soc_rst_n_d;
    logic        fetch_en_q, fetch_en_d;
    logic        cnt_zero;
    logic        lock_lost;

    cdc_sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_sync_locked (
        .clk_i  (core_clk),
        .rst_ni (reset_n),
        .d_i    (locked_i),
        .q_o    (locked_s)
    );

    cdc_sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_sync_hold (
        .clk_i  (core_clk),
        .rst_ni (reset_n),
        .d_i    (hold_i),
        .q_o    (hold_s)
    );

    assign cnt_zero  = (cnt_q == '0);
    // Loss during STABLE is just an unqualified lock, not a counted event.
    assign lock_lost = !locked_s && (state_q inside {StRstHold, StFetchWait, StRun, StHalt});

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        loss_d  = loss_q;

        unique case (state_q)
            StWaitLock: begin
                cnt_d = '0;
                if (locked_s) begin
                    state_d = StStable;
                    cnt_d   = LoadStable;
                end
            end
            StStable: begin
                if (!locked_s) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else if (cnt_zero) begin
                    state_d = StRstHold;
                    cnt_d   = LoadRst;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StRstHold: begin
                if (cnt_zero) begin
                    state_d = StFetchWait;
                    cnt_d   = LoadFetch;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StFetchWait: begin
                if (cnt_zero) begin
                    state_d = hold_s ? StHalt : StRun;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StRun: begin
                if (hold_s) begin
                    state_d = StHalt;
                end
            end
            StHalt: begin
                if (!hold_s) begin
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StWaitLock;
                cnt_d   = '0;
            end
        endcase

        // Lock loss overrides every transition computed above.
        if (lock_lost) begin
            state_d = StWaitLock;
            cnt_d   = '0;
            if (loss_q != LossMax) begin
                loss_d = loss_q + 1'b1;
            end
        end

        soc_rst_n_d = (state_d inside {StFetchWait, StRun, StHalt});
        fetch_en_d  = (state_d == StRun);
    end

    always_ff @(posedge core_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StWaitLock;
            cnt_q       <= '0;
            loss_q      <= '0;
            soc_rst_n_q <= 1'b0;
            fetch_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            loss_q      <= loss_d;
            soc_rst_n_q <= soc_rst_n_d;
            fetch_en_q  <= fetch_en_d;
        end
    end

    assign soc_reset_n_o   = soc_rst_n_q;
    assign fetch_enable_o  = fetch_en_q;
    assign state_o         = state_q;
    assign lock_loss_cnt_o = loss_q;

endmodule

// File: tb/tb_soc_boot_sequencer.sv
// Directed bench for soc_boot_sequencer: a per-edge vector table for the main
// boot / loss / hold flow plus hand sequences for multi-cycle corner cases.
module tb_soc_boot_sequencer;

    localparam logic [2:0] SWait  = 3'd0;
    localparam logic [2:0] SStab  = 3'd1;
    localparam logic [2:0] SRst   = 3'd2;
    localparam logic [2:0] SFetch = 3'd3;
    localparam logic [2:0] SRun   = 3'd4;
    localparam logic [2:0] SHalt  = 3'd5;

    logic       core_clk;
    logic       reset_n;
    logic       locked_i;
    logic       hold_i;
    logic       soc_reset_n_o;
    logic       fetch_enable_o;
    logic [2:0] state_o;
    logic [7:0] lock_loss_cnt_o;

    int n_pass;
    int n_total;

    typedef struct {
        logic       l;
        logic       h;
        logic [2:0] st;
        logic       r;
        logic       f;
        logic [7:0] c;
    } vec_t;

    vec_t vecs[$];

    soc_boot_sequencer #(
        .LOCK_STABLE_CYCLES (4),
        .RST_HOLD_CYCLES    (2),
        .FETCH_DELAY_CYCLES (3),
        .SYNC_STAGES        (2)
    ) dut (
        .core_clk        (core_clk),
        .reset_n         (reset_n),
        .locked_i        (locked_i),
        .hold_i          (hold_i),
        .soc_reset_n_o   (soc_reset_n_o),
        .fetch_enable_o  (fetch_enable_o),
        .state_o         (state_o),
        .lock_loss_cnt_o (lock_loss_cnt_o)
    );

    initial begin
        core_clk = 1'b0;
        forever #5 core_clk = ~core_clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void push(input int n, input logic l, input logic h,
                                 input logic [2:0] st, input logic r, input logic f,
                                 input logic [7:0] c);
        vec_t v;
        v.l = l; v.h = h; v.st = st; v.r = r; v.f = f; v.c = c;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [2:0] st, input logic r,
                         input logic f, input logic [7:0] c);
        n_total++;
        if (state_o === st && soc_reset_n_o === r && fetch_enable_o === f
            && lock_loss_cnt_o === c) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got state=%0d rst_n=%b fetch=%b cnt=%0d, want state=%0d rst_n=%b fetch=%b cnt=%0d",
                     name, state_o, soc_reset_n_o, fetch_enable_o, lock_loss_cnt_o,
                     st, r, f, c);
        end
    endtask

    task automatic step(input logic l, input logic h);
        locked_i = l;
        hold_i   = h;
        @(posedge core_clk);
        #1;
    endtask

    // Steps with fixed inputs until state_o == st or budget edges elapse.
    task automatic wait_state(input logic [2:0] st, input int budget, input logic l,
                              input logic h, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step(l, h);
            if (state_o === st) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Reset released at a falling edge; next rising edge is edge 1.
    task automatic do_reset();
        reset_n  = 1'b0;
        locked_i = 1'b0;
        hold_i   = 1'b0;
        repeat (2) @(posedge core_clk);
        @(negedge core_clk);
        reset_n = 1'b1;
    endtask

    initial begin
        bit ok;
        int timeouts;
        n_pass  = 0;
        n_total = 0;

        // Edge-by-edge expectations, starting at edge 1 after reset release.
        push(2, 1, 0, SWait,  0, 0, 0);  // edges 1-2: synchronizer filling
        push(4, 1, 0, SStab,  0, 0, 0);  // 3-6
        push(2, 1, 0, SRst,   0, 0, 0);  // 7-8
        push(3, 1, 0, SFetch, 1, 0, 0);  // 9-11: reset released at 9
        push(2, 1, 0, SRun,   1, 1, 0);  // 12-13: fetch at 12
        push(2, 0, 0, SRun,   1, 1, 0);  // 14-15: lock falls before 14
        push(2, 0, 0, SWait,  0, 0, 1);  // 16-17: k+2 outputs dropped
        push(2, 1, 0, SWait,  0, 0, 1);  // 18-19: relock
        push(4, 1, 0, SStab,  0, 0, 1);  // 20-23: full STABLE period again
        push(2, 1, 0, SRst,   0, 0, 1);  // 24-25
        push(3, 1, 0, SFetch, 1, 0, 1);  // 26-28
        push(1, 1, 0, SRun,   1, 1, 1);  // 29
        push(2, 1, 1, SRun,   1, 1, 1);  // 30-31: hold rises before 30
        push(1, 1, 1, SHalt,  1, 0, 1);  // 32
        push(2, 1, 0, SHalt,  1, 0, 1);  // 33-34: hold released
        push(1, 1, 0, SRun,   1, 1, 1);  // 35
        push(2, 0, 1, SRun,   1, 1, 1);  // 36-37: lock loss + hold together
        push(1, 0, 1, SWait,  0, 0, 2);  // 38: loss wins over hold

        do_reset();
        check("reset_state", SWait, 0, 0, 0);
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].l, vecs[i].h);
            check($sformatf("vec_edge%0d", i + 1), vecs[i].st, vecs[i].r, vecs[i].f,
                  vecs[i].c);
        end

        // Early lock drop in STABLE: not counted, full period restarts.
        do_reset();
        repeat (4) step(1, 0);                 // edges 1-4, STABLE since 3
        check("early_in_stable", SStab, 0, 0, 0);
        step(0, 0);                            // 5
        step(0, 0);                            // 6
        step(1, 0);                            // 7: locked_s low seen here
        check("early_back_wait", SWait, 0, 0, 0);
        step(1, 0);                            // 8
        check("early_still_wait", SWait, 0, 0, 0);
        repeat (4) step(1, 0);                 // 9-12
        check("early_full_stable", SStab, 0, 0, 0);
        step(1, 0);                            // 13
        check("early_rst_hold", SRst, 0, 0, 0);

        // Hold asserted so hold_s is high at the FETCH_WAIT terminal count.
        do_reset();
        repeat (9) step(1, 0);                 // edge 9: FETCH_WAIT
        check("hold_fw_enter", SFetch, 1, 0, 0);
        step(1, 1);                            // 10
        step(1, 1);                            // 11
        check("hold_fw_wait", SFetch, 1, 0, 0);
        step(1, 1);                            // 12: terminal count -> HALT
        check("hold_fw_halt", SHalt, 1, 0, 0);

        // 300 lock losses: counter saturates.
        do_reset();
        timeouts = 0;
        for (int i = 0; i < 300; i++) begin
            wait_state(SRst, 30, 1, 0, ok);
            if (!ok) timeouts++;
            wait_state(SWait, 10, 0, 0, ok);
            if (!ok) timeouts++;
        end
        n_total++;
        if (timeouts == 0) n_pass++;
        else $display("FAIL sat_timeouts: got %0d timeouts, want 0", timeouts);
        check("sat_255", SWait, 0, 0, 8'd255);

        // Async reset mid-FETCH_WAIT clears everything without a clock edge.
        wait_state(SFetch, 30, 1, 0, ok);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL reach_fetch_wait: got state=%0d, want %0d", state_o, SFetch);
        check("pre_async_reset", SFetch, 1, 0, 8'd255);
        #1 reset_n = 1'b0;
        #1;
        check("async_reset", SWait, 0, 0, 0);
        #20;
        check("async_reset_held", SWait, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
